pcm_to_pdm: RTL
===============

// Module: pcm_to_pdm
// PURPOSE
//  Converts 16-bit signed PCM (44 kHz, valid/ready) to a 1-bit PDM stream, one bit per clk (4.4 MHz PDM clock).
//  CIC interpolator (xINTERP) followed by a 2nd-order sigma-delta modulator; drives the PDM output pin / amp.
//  Playback counterpart of the mic path: same clock, same sample rate, same PCM format.
// PARAMETERS
//  INTERP     100  interpolation ratio (clk cycles per PCM sample)
//  CIC_ORDER  3    CIC stages (comb and integrator count), 1..5
// PORTS
//  clk        in   1   PDM bit clock; all logic on posedge
//  rst        in   1   reset, synchronous, active-high
//  pcm_in     in   16  signed PCM sample
//  pcm_valid  in   1   pcm_in valid
//  pcm_ready  out  1   block can accept pcm_in this cycle
//  pdm_out    out  1   registered PDM bit
//  underrun   out  1   1-cycle pulse: no sample available at a load strobe
// BEHAVIOUR
//  Reset: pdm_out=0, pcm_ready=0 while rst, underrun=0; hold reg, phase counter, combs, integrators, modulator state = 0.
//  Reset mid-operation discards held sample and all filter state; no partial output after rst deasserts.
//  Phase counter 0..INTERP-1, wraps; load strobe when phase==INTERP-1.
//  Input buffer: 1-deep hold register. pcm_ready = !hold_full && !rst. Accept on pcm_valid && pcm_ready.
//  At strobe: hold_full -> consume hold (hold_full<=0); else if pcm_valid (bypass) -> consume pcm_in directly;
//    else repeat last consumed sample and pulse underrun next cycle. Acceptance and consumption never double-count.
//  Comb chain (sample rate): evaluated in strobe cycle, result registered as comb_out; delay regs update on strobe only.
//  Integrators (clk rate): stage0 adds comb_out in the cycle after strobe (phase==0), 0 otherwise (zero-stuffing);
//    stage k adds stage k-1 registered output every cycle.
//  Width: ACC_W = 16 + CIC_ORDER*$clog2(INTERP); all CIC regs ACC_W, two's-complement wrap permitted.
//  Scaling: x = integ[CIC_ORDER-1] >>> SHIFT, SHIFT = $clog2(INTERP**(CIC_ORDER-1)) (14 at defaults; DC gain 10000/16384),
//    saturated to 16 bits, registered.
//  Modulator (CIFB): fb = pdm_out ? +32768 : -32768; s1 <= s1 + x - fb; s2 <= s2 + s1 - fb;
//    pdm_out <= (s2 >= 0). s1,s2 SD_W=24 bits, saturating (never wrap).
//  Latency strobe -> first affected pdm_out bit: fixed CIC_ORDER+5 clk.
//  Idle (reset, no samples ever): x=0 -> pdm_out toggles ~50% duty (silence).
// CONFIGURATION
//  PCM_TO_PDM_DITHER_EN defined: 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1, seed 16'hACE1 on rst) steps every clk;
//    modulator input = x + signed(lfsr[3:0]) - 8 (pre-saturation). Breaks idle tones.
//  Undefined: no LFSR logic; modulator input = x exactly. Everything else identical.
// STRUCTURE
//  pdm_pkg: PCM_W=16, SD_W=24, FB_MAG=32768, LFSR_POLY/LFSR_SEED, typedef logic signed [15:0] pcm_t.
//  Sub-module sd_mod2: 2nd-order modulator (x in, pdm_out, s1/s2 state, saturation, optional dither).
//  Top holds hold register, phase counter, CIC comb/integrator arrays, scaling.
// TESTING
//  Zero input, pcm_valid always high, 20000 clk -> pdm_out ones density 0.500 +/-0.005; underrun never.
//  DC +16384 -> x settles to 10000; density 0.653 +/-0.005. DC -32768 -> x=-20000; density 0.195 +/-0.005.
//  pcm_valid held high -> exactly one acceptance per 100 clk in steady state; pcm_ready low between strobes.
//  One sample then pcm_valid=0 -> underrun pulses once per 100 clk, 1 cycle wide; density keeps last-sample value.
//  Sample presented only in strobe cycle with hold empty -> bypass taken, no underrun pulse.
//  rst asserted mid-stream for 3 clk -> all outputs at reset values in next cycle, pcm_ready=1 after release,
//    idle density 0.5; repeat each case with PCM_TO_PDM_DITHER_EN (densities within +/-0.01).

Source files
------------

// File: rtl/pdm_pkg.sv
// Shared widths, constants and helpers for the PCM-to-PDM playback path.
package pdm_pkg;

   localparam int unsigned PCM_W  = 16;
   localparam int unsigned SD_W   = 24;
   localparam int          FB_MAG = 32768;

   // Right-shift Galois form of x^16+x^14+x^13+x^11+1
   localparam logic [15:0] LFSR_POLY = 16'hB400;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   typedef logic signed [PCM_W-1:0] pcm_t;
   typedef logic signed [SD_W-1:0]  sd_t;

   typedef enum logic [1:0] {
      SRC_HOLD,
      SRC_BYPASS,
      SRC_REPEAT
   } src_e;

   localparam logic signed [SD_W+1:0] SD_WIDE_HI = $signed({3'b000, {(SD_W-1){1'b1}}});
   localparam logic signed [SD_W+1:0] SD_WIDE_LO = $signed({3'b111, {(SD_W-1){1'b0}}});
   localparam sd_t SD_MAX = {1'b0, {(SD_W-1){1'b1}}};
   localparam sd_t SD_MIN = {1'b1, {(SD_W-1){1'b0}}};

   function automatic sd_t sat_sd(input logic signed [SD_W+1:0] v);
      sd_t r;
      if (v > SD_WIDE_HI)
         r = SD_MAX;
      else if (v < SD_WIDE_LO)
         r = SD_MIN;
      else
         r = v[SD_W-1:0];
      return r;
   endfunction

endpackage

// File: rtl/sd_mod2.sv
// Second-order CIFB sigma-delta modulator with saturating integrators.
// PCM_TO_PDM_DITHER_EN adds a small LFSR dither to the modulator input.
module sd_mod2
   import pdm_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [PCM_W-1:0] x,
   output logic                    pdm_out
);

   localparam int unsigned MW = SD_W + 2;
   typedef logic signed [MW-1:0] wide_t;

   localparam wide_t FB_POS = wide_t'(FB_MAG);
   localparam wide_t FB_NEG = -FB_POS;

   sd_t   s1;
   sd_t   s2;
   wide_t x_in;
   wide_t fb;
   wide_t s1_sum;
   wide_t s2_sum;

`ifdef PCM_TO_PDM_DITHER_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk) begin
      if (rst)
         lfsr <= LFSR_SEED;
      else
         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_POLY : 16'h0000);
   end

   // Dither spans -8..+7, centred on zero
   always_comb begin
      x_in = wide_t'(x) + wide_t'($signed({1'b0, lfsr[3:0]})) - wide_t'(8);
   end
`else
   always_comb begin
      x_in = wide_t'(x);
   end
`endif

   always_comb begin
      fb     = pdm_out ? FB_POS : FB_NEG;
      s1_sum = wide_t'(s1) + x_in - fb;
      s2_sum = wide_t'(s2) + wide_t'(s1) - fb;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1      <= '0;
         s2      <= '0;
         pdm_out <= 1'b0;
      end else begin
         s1      <= sat_sd(s1_sum);
         s2      <= sat_sd(s2_sum);
         pdm_out <= ~s2[SD_W-1];
      end
   end

endmodule

// File: rtl/pcm_to_pdm.sv
// PCM (valid/ready, one sample per INTERP clk) to 1-bit PDM: CIC interpolator + sd_mod2.
// Optional build macro PCM_TO_PDM_DITHER_EN enables modulator dither.
module pcm_to_pdm
   import pdm_pkg::*;
#(
   parameter int unsigned INTERP    = 100,
   parameter int unsigned CIC_ORDER = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [PCM_W-1:0] pcm_in,
   input  logic                    pcm_valid,
   output logic                    pcm_ready,
   output logic                    pdm_out,
   output logic                    underrun
);

   localparam int unsigned PH_W  = (INTERP > 1) ? $clog2(INTERP) : 1;
   localparam int unsigned ACC_W = PCM_W + CIC_ORDER * $clog2(INTERP);
   localparam int unsigned SHIFT = $clog2(INTERP ** (CIC_ORDER - 1));

   typedef logic signed [ACC_W-1:0] acc_t;

   localparam logic [PH_W-1:0] PH_LAST = PH_W'(INTERP - 1);
   localparam acc_t PCM_HI = acc_t'($signed({1'b0, {(PCM_W-1){1'b1}}}));
   localparam acc_t PCM_LO = acc_t'($signed({1'b1, {(PCM_W-1){1'b0}}}));

   logic [PH_W-1:0] phase;
   logic            strobe;
   logic            hold_full;
   pcm_t            hold_data;
   pcm_t            last_sample;
   pcm_t            sample;
   src_e            src;

   acc_t comb_dly [CIC_ORDER];
   acc_t comb_tap [CIC_ORDER];
   acc_t comb_res;
   acc_t comb_out;
   acc_t integ    [CIC_ORDER];
   acc_t scaled;
   pcm_t x_sat;
   pcm_t x;

   assign pcm_ready = !hold_full && !rst;
   assign strobe    = (phase == PH_LAST);

   always_ff @(posedge clk) begin
      if (rst)
         phase <= '0;
      else if (strobe)
         phase <= '0;
      else
         phase <= phase + 1'b1;
   end

   // A bypass at the strobe consumes pcm_in without filling hold, so it counts once
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_full <= 1'b0;
         hold_data <= '0;
      end else if (strobe) begin
         hold_full <= 1'b0;
      end else if (pcm_valid && pcm_ready) begin
         hold_full <= 1'b1;
         hold_data <= pcm_in;
      end
   end

   always_comb begin
      src = SRC_REPEAT;
      if (hold_full)
         src = SRC_HOLD;
      else if (pcm_valid)
         src = SRC_BYPASS;
   end

   always_comb begin
      case (src)
         SRC_HOLD:   sample = hold_data;
         SRC_BYPASS: sample = pcm_in;
         default:    sample = last_sample;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_sample <= '0;
         underrun    <= 1'b0;
      end else begin
         underrun <= strobe && (src == SRC_REPEAT);
         if (strobe)
            last_sample <= sample;
      end
   end

   always_comb begin
      acc_t acc;
      acc      = acc_t'(sample);
      comb_tap = '{default: '0};
      for (int unsigned i = 0; i < CIC_ORDER; i++) begin
         comb_tap[i] = acc;
         acc         = acc - comb_dly[i];
      end
      comb_res = acc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         comb_dly <= '{default: '0};
         comb_out <= '0;
      end else if (strobe) begin
         for (int unsigned i = 0; i < CIC_ORDER; i++)
            comb_dly[i] <= comb_tap[i];
         comb_out <= comb_res;
      end
   end

   // Zero-stuffing: comb_out enters stage 0 only in the cycle after the strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         integ <= '{default: '0};
      end else begin
         integ[0] <= integ[0] + ((phase == '0) ? comb_out : '0);
         for (int unsigned k = 1; k < CIC_ORDER; k++)
            integ[k] <= integ[k] + integ[k-1];
      end
   end

   always_comb begin
      scaled = integ[CIC_ORDER-1] >>> SHIFT;
      if (scaled > PCM_HI)
         x_sat = {1'b0, {(PCM_W-1){1'b1}}};
      else if (scaled < PCM_LO)
         x_sat = {1'b1, {(PCM_W-1){1'b0}}};
      else
         x_sat = scaled[PCM_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst)
         x <= '0;
      else
         x <= x_sat;
   end

   sd_mod2 u_mod (
      .clk     (clk),
      .rst     (rst),
      .x       (x),
      .pdm_out (pdm_out)
   );

endmodule
